// File: rtl/hermitian_demapping_if.sv
// Bundle carrying FFT bins into the Hermitian demapper and combined
// subcarriers (plus frame status pulses) back out.
//   data_in_re/im    : 28-bit two's-complement FFT bin
//   data_in_index    : bin index 0..N-1, natural order
//   data_in_valid    : input beat qualifier
//   data_out_re/im   : 28-bit combined subcarrier
//   data_out_index   : subcarrier index k
//   data_out_valid   : output beat qualifier
//   frame_done       : pulse on the last output beat of a frame
//   frame_err        : pulse one cycle after an index discontinuity
// master = bin source / result sink, slave = the demapper.
interface hermitian_demapping_if;
    logic [27:0] data_in_re;
    logic [27:0] data_in_im;
    logic [15:0] data_in_index;
    logic        data_in_valid;
    logic [27:0] data_out_re;
    logic [27:0] data_out_im;
    logic [15:0] data_out_index;
    logic        data_out_valid;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output data_in_re, data_in_im, data_in_index, data_in_valid,
        input  data_out_re, data_out_im, data_out_index, data_out_valid,
        input  frame_done, frame_err
    );

    modport slave (
        input  data_in_re, data_in_im, data_in_index, data_in_valid,
        output data_out_re, data_out_im, data_out_index, data_out_valid,
        output frame_done, frame_err
    );
endinterface

// File: rtl/hermitian_demapping.sv
// Hermitian demapper: takes a full N-point FFT frame in natural order and
// emits, for k = N/2-1 down to FIRST_BIN, the mean of X[k] and conj(X[N-k]).
// Bins 1..N/2-1 are buffered during FILL; bins N/2+1..N-1 are paired with
// the buffered partner during COMBINE. DC and Nyquist are dropped.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : hermitian_demapping_if.slave (input bins, output subcarriers,
//           frame_done / frame_err pulses)
// Latency from an input bin j to the output for k = N-j is two cycles:
// a registered buffer read followed by registered arithmetic.
module hermitian_demapping #(
    parameter int FFT_SIZE  = 256,
    parameter int FIRST_BIN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hermitian_demapping_if.slave bus
);
    localparam int HALF   = FFT_SIZE / 2;
    localparam int ADDR_W = $clog2(HALF);

    localparam logic [15:0] N_IDX    = 16'(FFT_SIZE);
    localparam logic [15:0] HALF_IDX = 16'(HALF);
    localparam logic [15:0] LAST_IDX = 16'(FFT_SIZE - 1);
    localparam logic [15:0] FIRST_K  = 16'(FIRST_BIN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_COMBINE = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] exp_idx_r;

    // Lower-half buffer: {re, im} per bin k.
    logic [55:0] mem_r [0:HALF-1];

    logic        idx_match_s;
    logic [15:0] k_s;
    logic        wr_en_s;
    logic        rd_en_s;

    logic [27:0] rd_re_r;
    logic [27:0] rd_im_r;
    logic [27:0] xj_re_r;
    logic [27:0] xj_im_r;
    logic [15:0] p1_k_r;
    logic        p1_valid_r;
    logic        p1_last_r;

    logic signed [28:0] sum_re_s;
    logic signed [28:0] dif_im_s;

    logic [27:0] out_re_r;
    logic [27:0] out_im_r;
    logic [15:0] out_idx_r;
    logic        out_valid_r;
    logic        done_r;
    logic        err_r;

    // Beat decode: index check, partner address and buffer write/read enables.
    always_comb begin
        idx_match_s = 1'b0;
        k_s         = 16'd0;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        if (bus.data_in_valid) begin
            idx_match_s = (bus.data_in_index == exp_idx_r);
            k_s         = N_IDX - bus.data_in_index;
        end else begin
            idx_match_s = 1'b0;
            k_s         = 16'd0;
        end
        case (state_r)
            // Index 0 never matches in FILL (expected index starts at 1),
            // and index N/2 is excluded here, so DC and Nyquist are dropped.
            ST_FILL: begin
                wr_en_s = idx_match_s && (bus.data_in_index < HALF_IDX);
            end
            // Only partners inside the data-bearing range produce output.
            ST_COMBINE: begin
                rd_en_s = idx_match_s && (k_s >= FIRST_K);
            end
            default: begin
                wr_en_s = 1'b0;
                rd_en_s = 1'b0;
            end
        endcase
    end

    // Buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[bus.data_in_index[ADDR_W-1:0]] <= {bus.data_in_re, bus.data_in_im};
        end
    end

    // Frame-tracking FSM and the one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            exp_idx_r <= 16'd0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Stray non-zero beats are silently ignored here.
                    if (bus.data_in_valid && (bus.data_in_index == 16'd0)) begin
                        state_r   <= ST_FILL;
                        exp_idx_r <= 16'd1;
                    end
                end
                ST_FILL, ST_COMBINE: begin
                    if (bus.data_in_valid) begin
                        if (idx_match_s) begin
                            exp_idx_r <= exp_idx_r + 16'd1;
                            if ((state_r == ST_FILL) && (bus.data_in_index == HALF_IDX)) begin
                                state_r <= ST_COMBINE;
                            end else if ((state_r == ST_COMBINE) && (bus.data_in_index == LAST_IDX)) begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            // Discontinuity: abort; an index-0 beat opens a new frame.
                            err_r <= 1'b1;
                            if (bus.data_in_index == 16'd0) begin
                                state_r   <= ST_FILL;
                                exp_idx_r <= 16'd1;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    exp_idx_r <= 16'd0;
                end
            endcase
        end
    end

    // Stage 1: registered read of X[k] alongside the incoming X[j].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_re_r    <= 28'd0;
            rd_im_r    <= 28'd0;
            xj_re_r    <= 28'd0;
            xj_im_r    <= 28'd0;
            p1_k_r     <= 16'd0;
            p1_valid_r <= 1'b0;
            p1_last_r  <= 1'b0;
        end else begin
            p1_valid_r <= rd_en_s;
            if (rd_en_s) begin
                rd_re_r   <= mem_r[k_s[ADDR_W-1:0]][55:28];
                rd_im_r   <= mem_r[k_s[ADDR_W-1:0]][27:0];
                xj_re_r   <= bus.data_in_re;
                xj_im_r   <= bus.data_in_im;
                p1_k_r    <= k_s;
                p1_last_r <= (k_s == FIRST_K);
            end
        end
    end

    // Sign-extend to 29 bits so the sum/difference can never wrap.
    always_comb begin
        sum_re_s = $signed({rd_re_r[27], rd_re_r}) + $signed({xj_re_r[27], xj_re_r});
        dif_im_s = $signed({rd_im_r[27], rd_im_r}) - $signed({xj_im_r[27], xj_im_r});
    end

    // Stage 2: halve (floor) and register outputs; zeros when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_re_r    <= 28'd0;
            out_im_r    <= 28'd0;
            out_idx_r   <= 16'd0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else if (p1_valid_r) begin
            out_re_r    <= 28'(sum_re_s >>> 1);
            out_im_r    <= 28'(dif_im_s >>> 1);
            out_idx_r   <= p1_k_r;
            out_valid_r <= 1'b1;
            done_r      <= p1_last_r;
        end else begin
            out_re_r    <= 28'd0;
            out_im_r    <= 28'd0;
            out_idx_r   <= 16'd0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end
    end

    assign bus.data_out_re    = out_re_r;
    assign bus.data_out_im    = out_im_r;
    assign bus.data_out_index = out_idx_r;
    assign bus.data_out_valid = out_valid_r;
    assign bus.frame_done     = done_r;
    assign bus.frame_err      = err_r;
endmodule

// File: tb/tb_hermitian_demapping.sv
// Directed bench for hermitian_demapping with N=16, FIRST_BIN=1.
// Inputs are driven and outputs sampled on the falling edge; each expected
// output beat is queued with the exact cycle it must appear in (input
// cycle + 2), so latency, ordering and values are all checked together.
module tb_hermitian_demapping;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   err_due;

    hermitian_demapping_if bus_if ();

    hermitian_demapping #(.FFT_SIZE(16), .FIRST_BIN(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct {
        int          due;
        logic [27:0] re;
        logic [27:0] im;
        logic [15:0] idx;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    logic [27:0] fre [16];
    logic [27:0] fim [16];
    logic [27:0] ere [8];
    logic [27:0] eim [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if ((exp_q.size() > 0) && (exp_q[0].due < cyc)) begin
            e = exp_q.pop_front();
            check_eq("missed_beat_cycle", 32'(cyc), 32'(e.due));
        end
        if ((exp_q.size() > 0) && (exp_q[0].due == cyc)) begin
            e = exp_q.pop_front();
            check_eq("out_valid", 32'(bus_if.data_out_valid), 32'd1);
            check_eq("out_re", 32'(bus_if.data_out_re), 32'(e.re));
            check_eq("out_im", 32'(bus_if.data_out_im), 32'(e.im));
            check_eq("out_index", 32'(bus_if.data_out_index), 32'(e.idx));
            check_eq("frame_done", 32'(bus_if.frame_done), 32'(e.done));
        end else if (bus_if.data_out_valid || bus_if.frame_done) begin
            check_eq("spurious_out", 32'({bus_if.data_out_valid, bus_if.frame_done}), 32'd0);
        end
        if ((err_due == cyc) || bus_if.frame_err) begin
            check_eq("frame_err", 32'(bus_if.frame_err), 32'(err_due == cyc));
        end
    endtask

    // One cycle: check this cycle's outputs, then drive this cycle's input.
    task automatic tick(input logic v, input logic [27:0] re, input logic [27:0] im,
                        input logic [15:0] idx);
        @(negedge clk);
        check_outputs();
        bus_if.data_in_valid = v;
        bus_if.data_in_re    = re;
        bus_if.data_in_im    = im;
        bus_if.data_in_index = idx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 28'd0, 28'd0, 16'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_re"}, 32'(bus_if.data_out_re), 32'd0);
        check_eq({tag, "_im"}, 32'(bus_if.data_out_im), 32'd0);
        check_eq({tag, "_idx"}, 32'(bus_if.data_out_index), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus_if.data_out_valid), 32'd0);
        check_eq({tag, "_done"}, 32'(bus_if.frame_done), 32'd0);
        check_eq({tag, "_err"}, 32'(bus_if.frame_err), 32'd0);
    endtask

    // X[k]=(100k,10k), X[16-k]=(100k,-10k): every output is (100k,10k).
    task automatic load_base();
        for (int k = 1; k < 8; k++) begin
            fre[k]      = 28'(100 * k);
            fim[k]      = 28'(10 * k);
            fre[16 - k] = 28'(100 * k);
            fim[16 - k] = 28'(-10 * k);
            ere[k]      = 28'(100 * k);
            eim[k]      = 28'(10 * k);
        end
        fre[0] = 28'h1234567; fim[0] = 28'h0ABCDEF;
        fre[8] = 28'h7654321; fim[8] = 28'h0FEDCBA;
        ere[0] = 28'd0; eim[0] = 28'd0;
    endtask

    task automatic send_frame(input int stall_at, input bit first_err, input int abort_at);
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            if (j == abort_at) begin
                @(negedge clk);
                check_outputs();
                rst_n = 1'b0;
                bus_if.data_in_valid = 1'b0;
                #1;
                check_all_zero("reset_mid_frame");
                exp_q.delete();
                idle(2);
                rst_n = 1'b1;
                return;
            end
            if (j == stall_at) idle(3);
            tick(1'b1, fre[j], fim[j], 16'(j));
            if ((j == 0) && first_err) err_due = cyc + 1;
            if (j > 8) begin
                e.due  = cyc + 2;
                e.re   = ere[16 - j];
                e.im   = eim[16 - j];
                e.idx  = 16'(16 - j);
                e.done = (j == 15);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        err_due = -1;
        cyc     = 0;
        rst_n   = 1'b0;
        bus_if.data_in_valid = 1'b0;
        bus_if.data_in_re    = 28'd0;
        bus_if.data_in_im    = 28'd0;
        bus_if.data_in_index = 16'd0;

        idle(3);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        // Basic frame, then two back-to-back frames with corner values.
        load_base();
        send_frame(-1, 1'b0, -1);
        fre[3] = 28'd5; fim[3] = 28'hFFFFFFD;
        fre[13] = 28'd2; fim[13] = 28'd4;
        ere[3] = 28'd3; eim[3] = 28'hFFFFFFC;
        fre[7] = 28'h7FFFFFF; fim[7] = 28'h8000000;
        fre[9] = 28'h7FFFFFF; fim[9] = 28'h8000000;
        ere[7] = 28'h7FFFFFF; eim[7] = 28'd0;
        send_frame(-1, 1'b0, -1);
        load_base();
        fre[7] = 28'h8000000; fim[7] = 28'd0;
        fre[9] = 28'h8000000; fim[9] = 28'd0;
        ere[7] = 28'h8000000; eim[7] = 28'd0;
        send_frame(-1, 1'b0, -1);
        idle(3);

        // Stall of three cycles ahead of index 8.
        load_base();
        send_frame(8, 1'b0, -1);
        idle(3);

        // Discontinuity in FILL, stray beats in IDLE, then a clean frame.
        for (int j = 0; j < 6; j++) tick(1'b1, fre[j], fim[j], 16'(j));
        tick(1'b1, fre[9], fim[9], 16'd9);
        err_due = cyc + 1;
        tick(1'b1, fre[10], fim[10], 16'd10);
        tick(1'b1, fre[11], fim[11], 16'd11);
        idle(2);
        send_frame(-1, 1'b0, -1);
        idle(2);

        // Index 0 mid-frame restarts a new frame.
        for (int j = 0; j < 4; j++) tick(1'b1, fre[j], fim[j], 16'(j));
        send_frame(-1, 1'b1, -1);
        idle(2);

        // Reset during COMBINE at index 11, then a fresh frame.
        send_frame(-1, 1'b0, 11);
        idle(2);
        send_frame(-1, 1'b0, -1);

        idle(5);
        check_eq("pending_beats", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
